reg_file_sb: RTL and testbench

//  Parametrised architectural register file with per-register pending-write

---
 rtl/reg_file_sb_if.sv | 44 ++++
 rtl/reg_file_sb.sv | 145 ++++++++++++++
 tb/tb_reg_file_sb.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_sb_if.sv
// Command/response channel of reg_file_sb. Defining REG_FILE_WB_EN adds the
// always-accepted writeback port (i_wb_valid/i_wb_reg/i_wb_data).
interface reg_file_sb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int IDX_W      = 3
);
    logic                  i_valid;
    logic                  o_ready;
    logic [1:0]            i_cmd;
    logic [IDX_W-1:0]      i_reg_a;
    logic [IDX_W-1:0]      i_reg_b;
    logic [DATA_WIDTH-1:0] i_data;
    logic                  o_res_valid;
    logic                  i_res_ready;
    logic [DATA_WIDTH-1:0] o_data_a;
    logic [DATA_WIDTH-1:0] o_data_b;
    logic [1:0]            o_busy;
    logic                  o_err;
`ifdef REG_FILE_WB_EN
    logic                  i_wb_valid;
    logic [IDX_W-1:0]      i_wb_reg;
    logic [DATA_WIDTH-1:0] i_wb_data;

    modport slave (
        input  i_valid, i_cmd, i_reg_a, i_reg_b, i_data, i_res_ready,
        input  i_wb_valid, i_wb_reg, i_wb_data,
        output o_ready, o_res_valid, o_data_a, o_data_b, o_busy, o_err
    );
    modport master (
        output i_valid, i_cmd, i_reg_a, i_reg_b, i_data, i_res_ready,
        output i_wb_valid, i_wb_reg, i_wb_data,
        input  o_ready, o_res_valid, o_data_a, o_data_b, o_busy, o_err
    );
`else
    modport slave (
        input  i_valid, i_cmd, i_reg_a, i_reg_b, i_data, i_res_ready,
        output o_ready, o_res_valid, o_data_a, o_data_b, o_busy, o_err
    );
    modport master (
        output i_valid, i_cmd, i_reg_a, i_reg_b, i_data, i_res_ready,
        input  o_ready, o_res_valid, o_data_a, o_data_b, o_busy, o_err
    );
`endif
endinterface

// File: rtl/reg_file_sb.sv
// Register file with per-register pending-write counters; one command per cycle,
// registered response. Optional writeback port enabled by REG_FILE_WB_EN.
module reg_file_sb #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 8,
    parameter int PEND_W     = 2
) (
    input logic          clk,
    input logic          reset,
    reg_file_sb_if.slave bus
);
    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        CMD_READ  = 2'd0,
        CMD_WRITE = 2'd1,
        CMD_MARKD = 2'd2,
        CMD_CHECK = 2'd3
    } cmd_e;

    logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_w [NUM_REGS];
    logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
    logic [PEND_W-1:0]     pend_q [NUM_REGS];
    logic [PEND_W-1:0]     pend_w [NUM_REGS];
    logic [PEND_W-1:0]     pend_d [NUM_REGS];

    logic                  res_valid_q;
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
    logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
    logic [1:0]            busy_q, busy_d;
    logic                  err_q, err_d;

    cmd_e             cmd;
    logic [IDX_W-1:0] a_idx, b_idx;
    logic             a_ok, b_ok, uses_b, accept, ready;
    logic             wb_ok, wb_hit_a;

    assign cmd    = cmd_e'(bus.i_cmd);
    assign a_idx  = bus.i_reg_a;
    assign b_idx  = bus.i_reg_b;
    assign a_ok   = 32'(a_idx) < 32'(NUM_REGS);
    assign b_ok   = 32'(b_idx) < 32'(NUM_REGS);
    assign uses_b = (cmd == CMD_READ) || (cmd == CMD_CHECK);
    assign ready  = !reset && (!res_valid_q || bus.i_res_ready);
    assign accept = bus.i_valid && ready;

    always_comb begin
        regs_w = regs_q;
        pend_w = pend_q;
`ifdef REG_FILE_WB_EN
        wb_ok    = bus.i_wb_valid && (32'(bus.i_wb_reg) < 32'(NUM_REGS));
        wb_hit_a = wb_ok && (bus.i_wb_reg == a_idx);
        if (wb_ok) begin
            regs_w[bus.i_wb_reg] = bus.i_wb_data;
            if (pend_q[bus.i_wb_reg] != '0)
                pend_w[bus.i_wb_reg] = pend_q[bus.i_wb_reg] - 1'b1;
        end
`else
        wb_ok    = 1'b0;
        wb_hit_a = 1'b0;
`endif
        // Commands act on the post-writeback view, which gives forwarding for
        // READ/CHECK and the combined minus-two for WRITE against writeback.
        regs_d   = regs_w;
        pend_d   = pend_w;
        data_a_d = '0;
        data_b_d = '0;
        busy_d   = '0;
        err_d    = 1'b0;
        if (accept) begin
            busy_d[0] = a_ok && (pend_w[a_idx] != '0);
            busy_d[1] = uses_b && b_ok && (pend_w[b_idx] != '0);
            unique case (cmd)
                CMD_READ: begin
                    if (a_ok) data_a_d = regs_w[a_idx];
                    if (b_ok) data_b_d = regs_w[b_idx];
                    err_d = !(a_ok && b_ok);
                end
                CMD_CHECK: begin
                    if (a_ok) data_a_d = DATA_WIDTH'(pend_w[a_idx]);
                    if (b_ok) data_b_d = DATA_WIDTH'(pend_w[b_idx]);
                    err_d = !(a_ok && b_ok);
                end
                CMD_WRITE: begin
                    if (!a_ok) begin
                        err_d = 1'b1;
                    end else begin
                        regs_d[a_idx] = bus.i_data;
                        data_a_d      = bus.i_data;
                        if (pend_w[a_idx] != '0) pend_d[a_idx] = pend_w[a_idx] - 1'b1;
                        else                     err_d = 1'b1;
                    end
                end
                CMD_MARKD: begin
                    if (!a_ok) begin
                        err_d = 1'b1;
                    end else if (wb_hit_a) begin
                        // Increment and writeback decrement cancel exactly, even at 0.
                        pend_d[a_idx] = pend_q[a_idx];
                        data_a_d      = DATA_WIDTH'(pend_q[a_idx]);
                    end else if (pend_w[a_idx] == PEND_MAX) begin
                        err_d    = 1'b1;
                        data_a_d = DATA_WIDTH'(pend_w[a_idx]);
                    end else begin
                        pend_d[a_idx] = pend_w[a_idx] + 1'b1;
                        data_a_d      = DATA_WIDTH'(pend_d[a_idx]);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q      <= '{default: '0};
            pend_q      <= '{default: '0};
            res_valid_q <= 1'b0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            busy_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            regs_q <= regs_d;
            pend_q <= pend_d;
            if (accept) begin
                res_valid_q <= 1'b1;
                data_a_q    <= data_a_d;
                data_b_q    <= data_b_d;
                busy_q      <= busy_d;
                err_q       <= err_d;
            end else if (bus.i_res_ready) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.o_ready     = ready;
    assign bus.o_res_valid = res_valid_q;
    assign bus.o_data_a    = data_a_q;
    assign bus.o_data_b    = data_b_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_err       = err_q;
endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench for reg_file_sb with NUM_REGS=6 so that out-of-range indices
// are representable; writeback steps run only when REG_FILE_WB_EN is defined.
module tb_reg_file_sb;
    localparam logic [1:0] READ = 2'd0, WRITE = 2'd1, MARKD = 2'd2, CHECK = 2'd3;

    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    reg_file_sb_if #(.DATA_WIDTH(32), .IDX_W(3)) bus ();

    reg_file_sb #(.DATA_WIDTH(32), .NUM_REGS(6), .PEND_W(2)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [1:0] c, input logic [2:0] a, input logic [2:0] b,
                        input logic [31:0] d);
        @(negedge clk);
        bus.i_valid     = 1'b1;
        bus.i_cmd       = c;
        bus.i_reg_a     = a;
        bus.i_reg_b     = b;
        bus.i_data      = d;
        bus.i_res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
    endtask

    task automatic chk_res(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] busy, input logic err);
        chk({tag, ".valid"}, 32'(bus.o_res_valid), 32'd1);
        chk({tag, ".a"},     bus.o_data_a, a);
        chk({tag, ".b"},     bus.o_data_b, b);
        chk({tag, ".busy"},  32'(bus.o_busy), 32'(busy));
        chk({tag, ".err"},   32'(bus.o_err), 32'(err));
    endtask

    logic [31:0] exp_regs [6];
    logic [31:0] exp_pend [6];

    initial begin
        vectors         = 0;
        miscompares     = 0;
        reset           = 1'b1;
        bus.i_valid     = 1'b1;
        bus.i_cmd       = MARKD;
        bus.i_reg_a     = 3'd1;
        bus.i_reg_b     = 3'd0;
        bus.i_data      = '0;
        bus.i_res_ready = 1'b1;
`ifdef REG_FILE_WB_EN
        bus.i_wb_valid  = 1'b0;
        bus.i_wb_reg    = '0;
        bus.i_wb_data   = '0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst.ready",     32'(bus.o_ready), 32'd0);
        chk("rst.res_valid", 32'(bus.o_res_valid), 32'd0);
        chk("rst.data_a",    bus.o_data_a, 32'd0);
        chk("rst.busy",      32'(bus.o_busy), 32'd0);
        chk("rst.err",       32'(bus.o_err), 32'd0);
        bus.i_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("post_rst.ready", 32'(bus.o_ready), 32'd1);

        // 1: READ after reset; MARKD offered during reset must have been ignored
        send(READ, 3'd3, 3'd5, 32'h0);
        chk_res("t1.read", 32'h0, 32'h0, 2'b00, 1'b0);
        send(CHECK, 3'd1, 3'd1, 32'h0);
        chk_res("t1.check_r1", 32'h0, 32'h0, 2'b00, 1'b0);
        @(posedge clk);
        #1;
        chk("t1.drained", 32'(bus.o_res_valid), 32'd0);

        // 2: WRITE with no pending mark flags an error but still writes
        send(WRITE, 3'd2, 3'd0, 32'hDEADBEEF);
        chk_res("t2.write", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
        send(READ, 3'd2, 3'd0, 32'h0);
        chk_res("t2.read", 32'hDEADBEEF, 32'h0, 2'b00, 1'b0);

        // 3: MARKD to saturation, then CHECK and a consuming WRITE
        send(MARKD, 3'd1, 3'd0, 32'h0);
        chk_res("t3.markd1", 32'd1, 32'h0, 2'b00, 1'b0);
        send(MARKD, 3'd1, 3'd0, 32'h0);
        chk_res("t3.markd2", 32'd2, 32'h0, 2'b01, 1'b0);
        send(MARKD, 3'd1, 3'd0, 32'h0);
        chk_res("t3.markd3", 32'd3, 32'h0, 2'b01, 1'b0);
        send(MARKD, 3'd1, 3'd0, 32'h0);
        chk_res("t3.markd_sat", 32'd3, 32'h0, 2'b01, 1'b1);
        send(CHECK, 3'd1, 3'd2, 32'h0);
        chk_res("t3.check", 32'd3, 32'd0, 2'b01, 1'b0);
        send(WRITE, 3'd1, 3'd0, 32'h00001234);
        chk_res("t3.write", 32'h00001234, 32'h0, 2'b01, 1'b0);
        send(CHECK, 3'd2, 3'd1, 32'h0);
        chk_res("t3.check2", 32'd0, 32'd2, 2'b10, 1'b0);

        // 4: back-to-back accepts, then a 3-cycle response stall
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_cmd = READ; bus.i_reg_a = 3'd2; bus.i_reg_b = 3'd1;
        chk("t4.ready0", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        chk_res("t4.rd0", 32'hDEADBEEF, 32'h00001234, 2'b10, 1'b0);
        @(negedge clk);
        bus.i_reg_a = 3'd1; bus.i_reg_b = 3'd2;
        chk("t4.ready1", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        chk_res("t4.rd1", 32'h00001234, 32'hDEADBEEF, 2'b01, 1'b0);
        @(negedge clk);
        bus.i_reg_a = 3'd0; bus.i_reg_b = 3'd0; bus.i_res_ready = 1'b0;
        #1;
        chk("t4.stall_ready", 32'(bus.o_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t4.stall_ready_hold", 32'(bus.o_ready), 32'd0);
            chk_res("t4.stall_hold", 32'h00001234, 32'hDEADBEEF, 2'b01, 1'b0);
        end
        @(negedge clk);
        bus.i_res_ready = 1'b1;
        #1;
        chk("t4.release_ready", 32'(bus.o_ready), 32'd1);
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        chk_res("t4.after_stall", 32'h0, 32'h0, 2'b00, 1'b0);

        // 5: out-of-range indices (6 and 7) leave state untouched
        send(CHECK, 3'd7, 3'd1, 32'h0);
        chk_res("t5.check_bad_a", 32'h0, 32'd2, 2'b10, 1'b1);
        send(READ, 3'd2, 3'd6, 32'h0);
        chk_res("t5.read_bad_b", 32'hDEADBEEF, 32'h0, 2'b00, 1'b1);
        send(WRITE, 3'd6, 3'd0, 32'hFFFF0000);
        chk_res("t5.write_bad", 32'h0, 32'h0, 2'b00, 1'b1);
        send(MARKD, 3'd7, 3'd0, 32'h0);
        chk_res("t5.markd_bad", 32'h0, 32'h0, 2'b00, 1'b1);
        exp_regs = '{32'h0, 32'h00001234, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
        exp_pend = '{32'd0, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
        for (int r = 0; r < 6; r++) begin
            send(CHECK, 3'(r), 3'(r), 32'h0);
            chk("t5.pend", bus.o_data_a, exp_pend[r]);
            send(READ, 3'(r), 3'(r), 32'h0);
            chk("t5.reg", bus.o_data_b, exp_regs[r]);
        end

`ifdef REG_FILE_WB_EN
        // 6: writeback forwarding into a same-cycle READ
        send(MARKD, 3'd4, 3'd0, 32'h0);
        chk_res("t6.markd", 32'd1, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        bus.i_wb_valid = 1'b1; bus.i_wb_reg = 3'd4; bus.i_wb_data = 32'h55;
        bus.i_valid = 1'b1; bus.i_cmd = READ; bus.i_reg_a = 3'd4; bus.i_reg_b = 3'd4;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_wb_valid = 1'b0;
        chk_res("t6.wb_fwd", 32'h55, 32'h55, 2'b00, 1'b0);
        send(CHECK, 3'd4, 3'd1, 32'h0);
        chk_res("t6.pend_after_wb", 32'd0, 32'd2, 2'b10, 1'b0);
        // Writeback plus WRITE on r1 (pend 2) consumes both marks without error
        @(negedge clk);
        bus.i_wb_valid = 1'b1; bus.i_wb_reg = 3'd1; bus.i_wb_data = 32'hAAAA;
        bus.i_valid = 1'b1; bus.i_cmd = WRITE; bus.i_reg_a = 3'd1; bus.i_data = 32'hBBBB;
        @(posedge clk); #1;
        bus.i_valid = 1'b0; bus.i_wb_valid = 1'b0;
        chk_res("t6.wb_write", 32'hBBBB, 32'h0, 2'b01, 1'b0);
        send(READ, 3'd1, 3'd1, 32'h0);
        chk_res("t6.cmd_wins", 32'hBBBB, 32'hBBBB, 2'b00, 1'b0);
`endif

        // Reset mid-stream drops a held response and clears the file
        @(negedge clk);
        bus.i_valid = 1'b1; bus.i_cmd = READ; bus.i_reg_a = 3'd2; bus.i_reg_b = 3'd2;
        bus.i_res_ready = 1'b0;
        @(posedge clk); #1;
        bus.i_valid = 1'b0;
        chk("t7.held_valid", 32'(bus.o_res_valid), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t7.ready_in_reset", 32'(bus.o_ready), 32'd0);
        @(posedge clk); #1;
        chk("t7.valid_cleared", 32'(bus.o_res_valid), 32'd0);
        chk("t7.data_cleared",  bus.o_data_a, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        send(READ, 3'd2, 3'd1, 32'h0);
        chk_res("t7.regs_cleared", 32'h0, 32'h0, 2'b00, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
